readout_sequencer: RTL and testbench

//  Host-side controller for the event FIFO readout path. Decodes host command bytes from the UART RX,

---
 rtl/readout_sequencer_if.sv | 26 ++
 rtl/readout_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_readout_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_sequencer_if.sv
// Bundles the host, event-reader and UART-TX signals of the readout sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system's view.
interface readout_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic [7:0]       host_byte_i;
    logic             host_valid_i;
    logic [7:0]       cmd_o;
    logic [31:0]      event_half_i;
    logic             fifo_empty_i;
    logic [7:0]       tx_data_o;
    logic             tx_valid_o;
    logic             tx_ready_i;
    logic             busy_o;
    logic [CNT_W-1:0] events_sent_o;

    modport slave (
        input  host_byte_i, host_valid_i, event_half_i, fifo_empty_i, tx_ready_i,
        output cmd_o, tx_data_o, tx_valid_o, busy_o, events_sent_o
    );

    modport master (
        output host_byte_i, host_valid_i, event_half_i, fifo_empty_i, tx_ready_i,
        input  cmd_o, tx_data_o, tx_valid_o, busy_o, events_sent_o
    );
endinterface

// File: rtl/readout_sequencer.sv
// Host-side readout controller: decodes host 'r'/'f' commands, pulses the event reader's cmd
// input, captures each 32-bit event half and streams it MSB-first as 4 bytes to the UART TX.
module readout_sequencer #(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    readout_sequencer_if.slave  bus
);
    localparam int LAT_W = $clog2(LAT + 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_LAT_A    = 4'd2;
    localparam logic [3:0] S_TX_A     = 4'd3;
    localparam logic [3:0] S_CMD_B    = 4'd4;
    localparam logic [3:0] S_LAT_B    = 4'd5;
    localparam logic [3:0] S_TX_B     = 4'd6;
    localparam logic [3:0] S_NEXT     = 4'd7;
    localparam logic [3:0] S_EMPTY_TX = 4'd8;
    localparam logic [3:0] S_KILL     = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;

    localparam logic [7:0] CMD_NONE   = 8'h00;
    localparam logic [7:0] CMD_START  = 8'h73;
    localparam logic [7:0] CMD_HALF_B = 8'h62;
    localparam logic [7:0] CMD_ADV    = 8'h61;
    localparam logic [7:0] CMD_DONE   = 8'h64;
    localparam logic [7:0] CMD_KILL   = 8'h6B;
    localparam logic [7:0] HOST_READ  = 8'h72;
    localparam logic [7:0] HOST_FLUSH = 8'h66;
    localparam logic [7:0] BYTE_EMPTY = 8'h65;

    logic [3:0]       state_q, state_d;
    logic             burst_q, burst_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] events_sent_q, events_sent_d;
    logic             tx_fire_s;

    function automatic logic is_host_cmd(input logic [7:0] b);
        return (b == HOST_READ) || (b == HOST_FLUSH);
    endfunction

    assign tx_fire_s = tx_valid_q && bus.tx_ready_i;

    // Next-state, pulse and transmit-path decode; cmd pulses are set one cycle ahead so cmd_o is a flop.
    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        lat_cnt_d     = lat_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        shreg_d       = shreg_q;
        cmd_d         = CMD_NONE;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        events_sent_d = events_sent_q;

        case (state_q)
            S_IDLE: begin
                if (bus.host_valid_i && is_host_cmd(bus.host_byte_i)) begin
                    burst_d = (bus.host_byte_i == HOST_FLUSH);
                    cmd_d   = CMD_START;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bus.fifo_empty_i) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = BYTE_EMPTY;
                    state_d    = S_EMPTY_TX;
                end else begin
                    // The 's' pulse cycle itself counts as latency cycle 0.
                    lat_cnt_d = LAT_W'(1);
                    state_d   = S_LAT_A;
                end
            end
            S_LAT_A, S_LAT_B: begin
                if (lat_cnt_q == LAT_W'(LAT)) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = bus.event_half_i[31:24];
                    shreg_d    = {bus.event_half_i[23:0], 8'h00};
                    byte_cnt_d = 2'd0;
                    state_d    = (state_q == S_LAT_A) ? S_TX_A : S_TX_B;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_TX_A, S_TX_B: begin
                if (tx_fire_s) begin
                    if (byte_cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        if (state_q == S_TX_A) begin
                            cmd_d   = CMD_HALF_B;
                            state_d = S_CMD_B;
                        end else begin
                            events_sent_d = events_sent_q + CNT_W'(1);
                            state_d       = S_NEXT;
                        end
                    end else begin
                        tx_data_d  = shreg_q[31:24];
                        shreg_d    = {shreg_q[23:0], 8'h00};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            S_CMD_B: begin
                lat_cnt_d = LAT_W'(1);
                state_d   = S_LAT_B;
            end
            S_NEXT: begin
                if (burst_q && !bus.fifo_empty_i) begin
                    // 'a' becomes visible next cycle, which is latency cycle 0 of the new event.
                    cmd_d     = CMD_ADV;
                    lat_cnt_d = LAT_W'(0);
                    state_d   = S_LAT_A;
                end else begin
                    cmd_d   = CMD_DONE;
                    state_d = S_DONE;
                end
            end
            S_EMPTY_TX: begin
                if (tx_fire_s) begin
                    tx_valid_d = 1'b0;
                    cmd_d      = CMD_KILL;
                    state_d    = S_KILL;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            S_KILL, S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            burst_q       <= 1'b0;
            lat_cnt_q     <= '0;
            byte_cnt_q    <= 2'd0;
            shreg_q       <= 32'h0000_0000;
            cmd_q         <= CMD_NONE;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            events_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            lat_cnt_q     <= lat_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            shreg_q       <= shreg_d;
            cmd_q         <= cmd_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            events_sent_q <= events_sent_d;
        end
    end

    assign bus.cmd_o         = cmd_q;
    assign bus.tx_data_o     = tx_data_q;
    assign bus.tx_valid_o    = tx_valid_q;
    assign bus.busy_o        = busy_q;
    assign bus.events_sent_o = events_sent_q;
endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized bench for readout_sequencer: an event-reader/FIFO model plus per-command expectation
// queues derived from the host protocol, checked every cycle by a single compare process.
module tb_readout_sequencer;
    localparam int LAT   = 2;
    localparam int CNT_W = 4;

    localparam logic [7:0] C_S = 8'h73;
    localparam logic [7:0] C_B = 8'h62;
    localparam logic [7:0] C_A = 8'h61;
    localparam logic [7:0] C_D = 8'h64;
    localparam logic [7:0] C_K = 8'h6B;
    localparam logic [7:0] H_R = 8'h72;
    localparam logic [7:0] H_F = 8'h66;

    logic clk = 1'b0;
    logic reset;

    readout_sequencer_if #(.CNT_W(CNT_W)) bus ();

    readout_sequencer #(.LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int ready_pct   = 100;
    int xfer_cnt    = 0;

    logic [63:0]      fifo_q[$];
    logic [7:0]       exp_cmd_q[$];
    logic [8:0]       exp_byte_q[$];
    logic [7:0]       act_cmd_log[$];
    logic [7:0]       act_byte_log[$];
    logic [CNT_W-1:0] exp_events;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected reader cmds and TX bytes for an accepted host command, from the FIFO contents now.
    task automatic build_exp(input logic [7:0] c);
        int n;
        logic [63:0] ev;
        if (c == H_F) n = fifo_q.size();
        else          n = (fifo_q.size() > 0) ? 1 : 0;
        exp_cmd_q.push_back(C_S);
        if (n == 0) begin
            exp_byte_q.push_back({1'b0, 8'h65});
            exp_cmd_q.push_back(C_K);
        end else begin
            for (int i = 0; i < n; i++) begin
                ev = fifo_q[i];
                if (i > 0) exp_cmd_q.push_back(C_A);
                exp_cmd_q.push_back(C_B);
                for (int j = 0; j < 8; j++) exp_byte_q.push_back({(j == 7), ev[63-8*j -: 8]});
            end
            exp_cmd_q.push_back(C_D);
        end
    endtask

    // Single compare process: event-reader model, TX sink, and all per-cycle output checks.
    initial begin : env
        logic [63:0] cur_ev;
        logic [31:0] valid_half;
        logic [8:0]  e;
        logic [7:0]  prev_data, prev_cmd;
        logic        prev_valid, prev_ready, inc_pending;
        int          cyc, valid_cyc;
        cur_ev = 64'd0; valid_half = 32'd0; prev_data = 8'h00; prev_cmd = 8'h00;
        prev_valid = 1'b0; prev_ready = 1'b0; inc_pending = 1'b0; cyc = 0; valid_cyc = -100;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (reset) begin
                check("rst_cmd",      64'(bus.cmd_o),         64'h0);
                check("rst_tx_valid", 64'(bus.tx_valid_o),    64'h0);
                check("rst_tx_data",  64'(bus.tx_data_o),     64'h0);
                check("rst_busy",     64'(bus.busy_o),        64'h0);
                check("rst_events",   64'(bus.events_sent_o), 64'h0);
                fifo_q.delete(); exp_cmd_q.delete(); exp_byte_q.delete();
                exp_events  = '0;
                inc_pending = 1'b0;
                valid_cyc   = -100;
                prev_valid  = 1'b0;
                prev_cmd    = 8'h00;
                bus.fifo_empty_i = 1'b1;
                bus.event_half_i = $urandom;
                bus.tx_ready_i   = ($urandom_range(99) < ready_pct);
            end else begin
                if (inc_pending) exp_events = exp_events + 1'b1;
                inc_pending = 1'b0;
                check("events_sent", 64'(bus.events_sent_o), 64'(exp_events));
                bus.fifo_empty_i = (fifo_q.size() == 0);
                if (bus.cmd_o != 8'h00) begin
                    act_cmd_log.push_back(bus.cmd_o);
                    check("cmd_back_to_back", 64'(prev_cmd), 64'h0);
                    check("busy_during_cmd", 64'(bus.busy_o), 64'h1);
                    if (exp_cmd_q.size() == 0) check("cmd_unexpected", 64'(bus.cmd_o), 64'h0);
                    else                       check("cmd", 64'(bus.cmd_o), 64'(exp_cmd_q.pop_front()));
                    if (bus.cmd_o == C_A) check("a_while_empty", 64'(bus.fifo_empty_i), 64'h0);
                    if (bus.cmd_o == C_S || bus.cmd_o == C_A) begin
                        if (fifo_q.size() > 0) cur_ev = fifo_q.pop_front();
                        valid_cyc  = cyc + LAT;
                        valid_half = cur_ev[63:32];
                    end else if (bus.cmd_o == C_B) begin
                        valid_cyc  = cyc + LAT;
                        valid_half = cur_ev[31:0];
                    end
                end
                prev_cmd = bus.cmd_o;
                bus.event_half_i = (cyc == valid_cyc) ? valid_half : $urandom;
                if (prev_valid && !prev_ready) begin
                    check("tx_valid_hold", 64'(bus.tx_valid_o), 64'h1);
                    check("tx_data_hold",  64'(bus.tx_data_o),  64'(prev_data));
                end
                bus.tx_ready_i = ($urandom_range(99) < ready_pct);
                if (bus.tx_valid_o && bus.tx_ready_i) begin
                    act_byte_log.push_back(bus.tx_data_o);
                    xfer_cnt++;
                    if (exp_byte_q.size() == 0) begin
                        check("tx_unexpected", 64'(bus.tx_valid_o), 64'h0);
                    end else begin
                        e = exp_byte_q.pop_front();
                        check("tx_byte", 64'(bus.tx_data_o), 64'(e[7:0]));
                        if (e[8]) inc_pending = 1'b1;
                    end
                end
                prev_valid = bus.tx_valid_o;
                prev_ready = bus.tx_ready_i;
                prev_data  = bus.tx_data_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic send_host(input logic [7:0] b, input bit accept);
        if (accept) build_exp(b);
        bus.host_byte_i  = b;
        bus.host_valid_i = 1'b1;
        tick();
        bus.host_valid_i = 1'b0;
        bus.host_byte_i  = 8'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        tick();
        while ((bus.busy_o || exp_cmd_q.size() != 0 || exp_byte_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check({nm, "_timeout"},   64'(n >= 3000),          64'h0);
        check({nm, "_cmds_left"}, 64'(exp_cmd_q.size()),   64'h0);
        check({nm, "_tx_left"},   64'(exp_byte_q.size()),  64'h0);
        exp_cmd_q.delete();
        exp_byte_q.delete();
    endtask

    task automatic clear_logs();
        act_cmd_log.delete();
        act_byte_log.delete();
    endtask

    // Literal sequence pins, MSB-first in exp.
    task automatic check_log(input string nm, input bit is_cmd, input logic [191:0] exp, input int n);
        int sz;
        logic [7:0] a;
        sz = is_cmd ? act_cmd_log.size() : act_byte_log.size();
        check({nm, "_len"}, 64'(sz), 64'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            a = is_cmd ? act_cmd_log[i] : act_byte_log[i];
            check({nm, "_item"}, 64'(a), 64'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin : driver
        logic [7:0] b;
        int r, base, n;
        reset = 1'b1;
        bus.host_byte_i  = 8'h00;
        bus.host_valid_i = 1'b0;
        bus.tx_ready_i   = 1'b1;
        bus.fifo_empty_i = 1'b1;
        bus.event_half_i = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single read, always-ready sink
        fifo_q.push_back(64'h1122334455667788);
        clear_logs();
        send_host(H_R, 1'b1);
        wait_idle("t1");
        check_log("t1_cmds", 1'b1, 192'("sbd"), 3);
        check_log("t1_bytes", 1'b0, 192'(64'h1122334455667788), 8);
        check("t1_events", 64'(bus.events_sent_o), 64'h1);
        check("t1_busy", 64'(bus.busy_o), 64'h0);

        // Read with empty FIFO
        clear_logs();
        send_host(H_R, 1'b1);
        wait_idle("t2");
        check_log("t2_cmds", 1'b1, 192'("sk"), 2);
        check_log("t2_bytes", 1'b0, 192'(8'h65), 1);
        check("t2_events", 64'(bus.events_sent_o), 64'h1);

        // Flush of three events
        fifo_q.push_back(64'h0102030405060708);
        fifo_q.push_back(64'h1112131415161718);
        fifo_q.push_back(64'h2122232425262728);
        clear_logs();
        send_host(H_F, 1'b1);
        wait_idle("t3");
        check_log("t3_cmds", 1'b1, 192'("sbababd"), 7);
        check_log("t3_bytes", 1'b0, {64'h0102030405060708, 64'h1112131415161718, 64'h2122232425262728}, 24);
        check("t3_events", 64'(bus.events_sent_o), 64'h4);

        // Read with a stalling sink
        ready_pct = 70;
        fifo_q.push_back(64'h1122334455667788);
        clear_logs();
        send_host(H_R, 1'b1);
        wait_idle("t4");
        check_log("t4_bytes", 1'b0, 192'(64'h1122334455667788), 8);
        check("t4_events", 64'(bus.events_sent_o), 64'h5);

        // Host bytes while busy, then an unknown byte while idle
        ready_pct = 100;
        fifo_q.push_back(64'hCAFEF00DDEADBEEF);
        fifo_q.push_back(64'h0F1E2D3C4B5A6978);
        clear_logs();
        send_host(H_R, 1'b1);
        tick();
        send_host(H_R, 1'b0);
        send_host(8'h78, 1'b0);
        send_host(H_F, 1'b0);
        wait_idle("t5");
        check_log("t5_cmds", 1'b1, 192'("sbd"), 3);
        check("t5_events", 64'(bus.events_sent_o), 64'h6);
        check("t5_fifo_left", 64'(fifo_q.size()), 64'h1);
        clear_logs();
        send_host(8'h78, 1'b0);
        repeat (4) tick();
        check("t5_idle_busy", 64'(bus.busy_o), 64'h0);
        check_log("t5_idle_cmds", 1'b1, 192'h0, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            if (fifo_q.size() < 3) begin
                n = $urandom_range(2);
                for (int k = 0; k < n; k++) fifo_q.push_back({$urandom, $urandom});
            end
            case ($urandom_range(2))
                0:       ready_pct = 100;
                1:       ready_pct = 70;
                default: ready_pct = 35;
            endcase
            r = $urandom_range(99);
            if (r < 45)      b = H_R;
            else if (r < 90) b = H_F;
            else begin
                b = 8'($urandom);
                if (b == H_R || b == H_F) b = 8'h2E;
            end
            send_host(b, (b == H_R || b == H_F));
            if ((b == H_R || b == H_F) && $urandom_range(1) == 1) begin
                send_host(8'($urandom), 1'b0);
                send_host(8'($urandom), 1'b0);
            end
            wait_idle("rnd");
        end

        // Reset in the middle of a flush, during the second half of the first event
        ready_pct = 100;
        fifo_q.delete();
        for (int k = 0; k < 3; k++) fifo_q.push_back({$urandom, $urandom});
        base = xfer_cnt;
        send_host(H_F, 1'b1);
        n = 0;
        while (xfer_cnt < base + 5 && n < 200) begin
            tick();
            n++;
        end
        check("t6_reach_tx_b_timeout", 64'(n >= 200), 64'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        fifo_q.push_back(64'h8877665544332211);
        clear_logs();
        send_host(H_R, 1'b1);
        wait_idle("t6_after");
        check_log("t6_bytes", 1'b0, 192'(64'h8877665544332211), 8);
        check("t6_events", 64'(bus.events_sent_o), 64'h1);

        // Counter wrap at full scale
        for (int k = 0; k < 14; k++) begin
            fifo_q.push_back({$urandom, $urandom});
            send_host(H_R, 1'b1);
            wait_idle("wrap_fill");
        end
        check("wrap_full", 64'(bus.events_sent_o), 64'hF);
        fifo_q.push_back({$urandom, $urandom});
        send_host(H_R, 1'b1);
        wait_idle("wrap_last");
        check("wrap_zero", 64'(bus.events_sent_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
